// File: rtl/alu_issue_unit.sv
// alu_issue_unit: sequential front-end for a combinational MIPS-style ALU.
// Instructions are queued in a small FIFO and dequeued one at a time while run is high.
// The rs/rt fields of each dequeued instruction are rewritten to the ALU's fixed
// operand addresses (00000/00001), and the operand values come from an internal
// 32x32 register file. The ALU result and flags are captured one cycle later and
// written back to the register file.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 allow dequeue (an instruction already in flight always completes)
//   in_valid/in_ready/in_instr   instruction push handshake
//   ld_en/ld_addr/ld_data        register file preload port
//   rd_addr/rd_data              combinational debug read of the register file
//   alu_instruction/alu_regA/alu_regB   operands driven to the ALU
//   alu_result/alu_flags         ALU response
//   wb_valid/wb_we/wb_addr/wb_data/wb_flags   completion report
//   fifo_count                   FIFO occupancy
module alu_issue_unit #(
  parameter int unsigned DEPTH   = 4,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic                     ld_en,
  input  logic [4:0]               ld_addr,
  input  logic [31:0]              ld_data,
  input  logic [4:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic [31:0]              alu_instruction,
  output logic [31:0]              alu_regA,
  output logic [31:0]              alu_regB,
  input  logic [31:0]              alu_result,
  input  logic [2:0]               alu_flags,
  output logic                     wb_valid,
  output logic                     wb_we,
  output logic [4:0]               wb_addr,
  output logic [31:0]              wb_data,
  output logic [2:0]               wb_flags,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e      state_q;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [31:0] rf_q [32];
  logic [31:0] ir_q, op_a_q, op_b_q;

  logic        push, pop, exec;
  logic [31:0] head;
  logic [4:0]  head_rs, head_rt;
  logic [5:0]  opc;
  logic        is_rtype, is_itype;
  logic [4:0]  dest;
  logic        wr_en;
  logic [31:0] op_a_d, op_b_d;

  assign in_ready   = (count_q < CW'(DEPTH));
  assign fifo_count = count_q;
  assign push       = in_valid && in_ready;
  // The pop condition is the same in both states; in EXEC it means back-to-back issue.
  assign pop        = run && (count_q != '0);
  assign exec       = (state_q == StExec);

  assign head    = mem[rd_ptr_q];
  assign head_rs = head[25:21];
  assign head_rt = head[20:16];

  // Destination decode for the instruction currently in EXEC.
  assign opc      = ir_q[31:26];
  assign is_rtype = (opc == 6'b000000);
  assign is_itype = (opc >= 6'b001000) && (opc <= 6'b001110);
  assign dest     = is_rtype ? ir_q[15:11] : ir_q[20:16];
  assign wr_en    = exec && (is_rtype || is_itype) && !(ZERO_R0 && (dest == 5'd0));

  // Operand fetch with forwarding from a writeback landing on the same edge.
  always_comb begin
    op_a_d = rf_q[head_rs];
    if (wr_en && (dest == head_rs)) op_a_d = alu_result;
    if (ZERO_R0 && (head_rs == 5'd0)) op_a_d = '0;
    op_b_d = rf_q[head_rt];
    if (wr_en && (dest == head_rt)) op_b_d = alu_result;
    if (ZERO_R0 && (head_rt == 5'd0)) op_b_d = '0;
  end

  assign alu_instruction = exec ? {ir_q[31:26], 5'b00000, 5'b00001, ir_q[15:0]} : '0;
  assign alu_regA        = exec ? op_a_q : '0;
  assign alu_regB        = exec ? op_b_q : '0;

  assign rd_data = (ZERO_R0 && (rd_addr == 5'd0)) ? '0 : rf_q[rd_addr];

  // FIFO storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Register file: writeback is ordered after preload so it wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      if (ld_en) rf_q[ld_addr] <= ld_data;
      if (wr_en) rf_q[dest] <= alu_result;
    end
  end

  // Issue FSM with registered completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_flags <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      if (exec) begin
        wb_valid <= 1'b1;
        wb_we    <= wr_en;
        wb_addr  <= dest;
        wb_data  <= alu_result;
        wb_flags <= alu_flags;
      end
      if (pop) begin
        ir_q    <= head;
        op_a_q  <= op_a_d;
        op_b_q  <= op_b_d;
        state_q <= StExec;
      end else begin
        state_q <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit. A behavioural ALU model answers the DUT's ALU port;
// a reference register file predicts each completion, which is queued at push time
// and compared when wb_valid pulses.
module tb_alu_issue_unit;

  logic        clk, rst_n, run, in_valid, in_ready, ld_en;
  logic [31:0] in_instr, ld_data, rd_data;
  logic [4:0]  ld_addr, rd_addr, wb_addr;
  logic [31:0] alu_instruction, alu_regA, alu_regB, alu_result, wb_data;
  logic [2:0]  alu_flags, wb_flags;
  logic        wb_valid, wb_we;
  logic [2:0]  fifo_count;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] m_rf [32];
  int          tests_run = 0;
  int          tests_failed = 0;

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_flags(wb_flags), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU model: returns {overflow, negative, zero, result}.
  function automatic logic [34:0] alu_f(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r, simm, zimm;
    logic        ov;
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0, ins[15:0]};
    r = '0;
    ov = 1'b0;
    case (ins[31:26])
      6'b000000: begin
        case (ins[5:0])
          6'b100000: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
          6'b100001: r = a + b;
          6'b100010: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
          6'b100100: r = a & b;
          6'b100101: r = a | b;
          default:   r = '0;
        endcase
      end
      6'b001000: begin r = a + simm; ov = (a[31] == simm[31]) && (r[31] != a[31]); end
      6'b001001: r = a + simm;
      6'b001100: r = a & zimm;
      6'b001101: r = a | zimm;
      6'b000100, 6'b000101: r = a - b;
      default: r = '0;
    endcase
    return {ov, r[31], (r == 32'h0), r};
  endfunction

  assign {alu_flags, alu_result} = alu_f(alu_instruction, alu_regA, alu_regB);

  // Reference: predict completion in program order and update the model RF.
  task automatic model_push(input logic [31:0] ins);
    exp_t        e;
    logic [34:0] r;
    logic [5:0]  opc;
    logic [4:0]  d;
    opc = ins[31:26];
    r = alu_f(ins, m_rf[ins[25:21]], m_rf[ins[20:16]]);
    e.data  = r[31:0];
    e.flags = r[34:32];
    if (opc == 6'd0) begin
      d = ins[15:11]; e.we = 1'b1;
    end else if (opc >= 6'd8 && opc <= 6'd14) begin
      d = ins[20:16]; e.we = 1'b1;
    end else begin
      d = 5'd0; e.we = 1'b0;
    end
    if (d == 5'd0) e.we = 1'b0;
    e.addr = d;
    if (e.we) m_rf[d] = e.data;
    exp_q.push_back(e);
  endtask

  // Completion scoreboard.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wb_unexpected: got wb_valid=1 addr=%0d data=%h, required no completion",
                 wb_addr, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wb_we !== mon_e.we || (mon_e.we && wb_addr !== mon_e.addr) ||
            wb_data !== mon_e.data || wb_flags !== mon_e.flags) begin
          tests_failed++;
          $display("FAIL wb_check: got we=%b addr=%0d data=%h flags=%b, required we=%b addr=%0d data=%h flags=%b",
                   wb_we, wb_addr, wb_data, wb_flags, mon_e.we, mon_e.addr, mon_e.data,
                   mon_e.flags);
        end
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; in_valid = 1'b0; ld_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    if (a != 5'd0) m_rf[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic push(input logic [31:0] ins);
    in_valid = 1'b1; in_instr = ins;
    if (in_ready) model_push(ins);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    run = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d pending completions, required 0", exp_q.size());
    end
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] req);
    tests_run++;
    if (got !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    check32("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check32("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
    check32("reset_wb_valid_we", {30'd0, wb_valid, wb_we}, 32'd0);
    check32("reset_wb_addr_flags", {24'd0, wb_addr, wb_flags}, 32'd0);
    check32("reset_wb_data", wb_data, 32'd0);
    check32("reset_alu_instruction", alu_instruction, 32'd0);
  endtask

  task automatic test_add();
    reset_dut();
    preload(5'd2, 32'hFFFF_FFFF);
    preload(5'd3, 32'h8000_0000);
    push(32'h0043_2020);
    run = 1'b1;
    @(negedge clk);
    check32("add_alu_instruction", alu_instruction, 32'h0001_2020);
    check32("add_alu_regA", alu_regA, 32'hFFFF_FFFF);
    check32("add_alu_regB", alu_regB, 32'h8000_0000);
    drain();
    check32("add_wb_data_hold", wb_data, 32'h7FFF_FFFF);
    check32("add_wb_overflow", {31'd0, wb_flags[2]}, 32'd1);
    rd_addr = 5'd4; #1;
    check32("add_rd_r4", rd_data, 32'h7FFF_FFFF);
  endtask

  task automatic test_back_to_back();
    reset_dut();
    preload(5'd2, 32'hFFFF_FFFF);
    preload(5'd3, 32'h8000_0000);
    push(32'h0043_2020);
    push(32'h2485_0001);
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check32("b2b_forward_regA", alu_regA, 32'h7FFF_FFFF);
    check32("b2b_wb_valid_first", {31'd0, wb_valid}, 32'd1);
    @(negedge clk);
    check32("b2b_wb_valid_second", {31'd0, wb_valid}, 32'd1);
    drain();
    rd_addr = 5'd5; #1;
    check32("b2b_rd_r5", rd_data, 32'h8000_0000);
  endtask

  task automatic test_full();
    logic [31:0] ins;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      ins = 32'h3400_0000 | (32'(i + 1) << 16) | 32'(16'h0100 + i);
      push(ins);
    end
    check32("full_in_ready", {31'd0, in_ready}, 32'd0);
    check32("full_count", {29'd0, fifo_count}, 32'd4);
    push(32'h3405_0104);
    check32("full_count_after_5th", {29'd0, fifo_count}, 32'd4);
    check32("full_queued", exp_q.size(), 32'd4);
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("full_no_extra_wb", {31'd0, wb_valid}, 32'd0);
    end
    rd_addr = 5'd5; #1;
    check32("full_r5_untouched", rd_data, 32'd0);
  endtask

  task automatic test_branch();
    reset_dut();
    preload(5'd6, 32'h0000_ABCD);
    preload(5'd7, 32'h0000_ABCD);
    push(32'h10C7_000F);
    drain();
    check32("beq_zero_flag", {31'd0, wb_flags[0]}, 32'd1);
    rd_addr = 5'd6; #1;
    check32("beq_r6", rd_data, 32'h0000_ABCD);
    rd_addr = 5'd7; #1;
    check32("beq_r7", rd_data, 32'h0000_ABCD);
  endtask

  task automatic test_zero_r0();
    reset_dut();
    preload(5'd2, 32'h0000_0010);
    push(32'h2040_0001);
    drain();
    rd_addr = 5'd0; #1;
    check32("r0_reads_zero", rd_data, 32'd0);
  endtask

  task automatic test_reset_mid();
    reset_dut();
    preload(5'd2, 32'h0000_0001);
    push(32'h0042_1821);
    push(32'h0042_2021);
    push(32'h0042_2821);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check32("mid_count_before", {29'd0, fifo_count}, 32'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    check32("mid_count", {29'd0, fifo_count}, 32'd0);
    check32("mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    check32("mid_alu_instr", alu_instruction, 32'd0);
    check32("mid_alu_ops", alu_regA | alu_regB, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      check32("mid_rf_clear", rd_data, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check32("mid_no_completion", {31'd0, wb_valid}, 32'd0);
    end
    run = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; in_valid = 1'b0; in_instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_branch();
    test_zero_r0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
